// File: rtl/if_stage_if.sv
// Bundle of control, instruction-memory and IF/ID signals around the fetch stage.
// master = the fetch stage itself, slave = hazard control / memory / decode side.
interface if_stage_if;
  logic        stall;
  logic        flush;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_inst;
  logic        ifid_valid;
  logic        fault;

  modport master (
    input  stall, flush, br_taken, br_target, jump, jump_target, imem_data,
    output imem_addr, ifid_pc, ifid_pc4, ifid_inst, ifid_valid, fault
  );

  modport slave (
    output stall, flush, br_taken, br_target, jump, jump_target, imem_data,
    input  imem_addr, ifid_pc, ifid_pc4, ifid_inst, ifid_valid, fault
  );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, IF/ID pipeline register and a
// run/fault machine that stops fetching once the PC leaves the legal range.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ADDR_BITS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  if_stage_if.master bus
);

  typedef enum logic {RUN, FAULT} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] ifid_pc_reg, ifid_pc_next;
  logic [31:0] ifid_pc4_reg, ifid_pc4_next;
  logic [31:0] ifid_inst_reg, ifid_inst_next;
  logic        ifid_valid_reg, ifid_valid_next;
  logic        pc_illegal;
  logic        redirect;
  logic        bubble;
  logic        fetch;

  assign pc_illegal = (pc_reg[1:0] != 2'b00) || (pc_reg[31:ADDR_BITS+2] != '0);
  assign redirect   = bus.br_taken || bus.jump;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= RUN;
      pc_reg         <= RESET_PC;
      ifid_pc_reg    <= 32'h0;
      ifid_pc4_reg   <= 32'h0;
      ifid_inst_reg  <= 32'h0;
      ifid_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      ifid_pc_reg    <= ifid_pc_next;
      ifid_pc4_reg   <= ifid_pc4_next;
      ifid_inst_reg  <= ifid_inst_next;
      ifid_valid_reg <= ifid_valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    bubble     = 1'b0;
    fetch      = 1'b0;
    case (state_reg)
      RUN: begin
        if (bus.br_taken)   pc_next = bus.br_target;
        else if (bus.jump)  pc_next = bus.jump_target;
        else if (!bus.stall) pc_next = pc_reg + 32'd4;

        // Redirects and flush kill the fetched word even under stall.
        if (redirect || bus.flush) bubble = 1'b1;
        else if (!bus.stall) begin
          fetch  = !pc_illegal;
          bubble = pc_illegal;
        end

        // A stall never hides an illegal PC.
        if (pc_illegal) state_next = FAULT;
      end
      FAULT:   bubble = 1'b1;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    ifid_pc_next    = ifid_pc_reg;
    ifid_pc4_next   = ifid_pc4_reg;
    ifid_inst_next  = ifid_inst_reg;
    ifid_valid_next = ifid_valid_reg;
    if (bubble) begin
      ifid_pc_next    = 32'h0;
      ifid_pc4_next   = 32'h0;
      ifid_inst_next  = 32'h0;
      ifid_valid_next = 1'b0;
    end else if (fetch) begin
      ifid_pc_next    = pc_reg;
      ifid_pc4_next   = pc_reg + 32'd4;
      ifid_inst_next  = bus.imem_data;
      ifid_valid_next = 1'b1;
    end
  end

  assign bus.imem_addr  = pc_reg;
  assign bus.ifid_pc    = ifid_pc_reg;
  assign bus.ifid_pc4   = ifid_pc4_reg;
  assign bus.ifid_inst  = ifid_inst_reg;
  assign bus.ifid_valid = ifid_valid_reg;
  assign bus.fault      = (state_reg == FAULT);

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the MIPS datapath: owns the program counter, drives the word address into the combinational instruction memory, and captures the returned word into the IF/ID pipeline register.
- Accepts branch/jump redirects from downstream stages, plus stall and flush from hazard control.
- Contains a small run/fault state machine that halts fetching on an illegal PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_BITS, 10, instruction-memory word-index width; the legal PC range is 0 .. 4*2^ADDR_BITS-4.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC and IF/ID contents.
- flush  in  1  load a bubble into IF/ID.
- br_taken  in  1  branch redirect request.
- br_target  in  32  branch target byte address.
- jump  in  1  jump/jr redirect request.
- jump_target  in  32  jump target byte address.
- imem_addr  out  32  byte address to instruction memory; equals the PC.
- imem_data  in  32  instruction word returned combinationally for imem_addr.
- ifid_pc  out  32  PC of the instruction held in IF/ID.
- ifid_pc4  out  32  ifid_pc + 4.
- ifid_inst  out  32  instruction held in IF/ID; 32'h0 (NOP) when a bubble.
- ifid_valid  out  1  IF/ID holds a real instruction.
- fault  out  1  sticky; an illegal PC was produced.

Behaviour:
- One clock (clk). Reset rst_n is asynchronous and active-low; the polarity and synchronicity are fixed.
- Reset values: pc=RESET_PC, imem_addr=RESET_PC, ifid_pc=0, ifid_pc4=0, ifid_inst=0, ifid_valid=0, fault=0, state=RUN. Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.
- imem_addr = pc, combinationally. The instruction is captured at the same edge that advances the PC, giving a 1-cycle latency from PC to IF/ID.
- Illegal PC: pc[1:0]!=0, or pc[31:ADDR_BITS+2]!=0.
- States:
  - RUN: normal fetch.
  - FAULT: entered at the edge after pc becomes illegal while in RUN. Sets fault=1.
  - FAULT is left only by reset. In FAULT, pc is frozen and every edge writes a bubble into IF/ID.
- RUN next-PC priority, highest first:
  1. br_taken: pc <= br_target.
  2. jump: pc <= jump_target.
  3. stall: pc holds.
  4. Otherwise: pc <= pc+4, wrapping modulo 2^32.
- Redirect beats stall. br_taken and jump together: br_taken wins.
- RUN IF/ID update, highest first:
  1. br_taken, jump or flush: bubble (valid=0, inst=0, pc=0, pc4=0).
  2. stall: hold all IF/ID fields.
  3. Current pc legal: load {pc, pc+4, imem_data, valid=1}.
  4. Current pc illegal: bubble, and enter FAULT.
- Flush without a redirect does not alter pc sequencing.
- Targets are loaded unmodified, so a misaligned target is caught as illegal on the following cycle.
- A stall while pc is illegal still enters FAULT; a fault is never masked by a stall.
- Stall with flush and no redirect: pc holds, IF/ID bubbles.
- ifid_pc4 is always consistent with ifid_pc: either ifid_pc+4, or 0 for a bubble.

Test Plan:
- Reset release, no control for 4 edges -> imem_addr 0,4,8,12; ifid_pc 0,4,8 with ifid_inst = mem[0..2]; ifid_valid rises 1 edge after reset.
- Steady at pc=0x10, stall high 2 cycles -> pc stays 0x10, IF/ID holds the instruction at 0x0C; after release, pc=0x14 and ifid_pc=0x10.
- At pc=0x20, br_taken=1, br_target=0x100, with stall=1 and jump=1 (jump_target=0x200) -> next pc=0x100, IF/ID bubble (valid 0, inst 0); next edge ifid_pc=0x100.
- flush alone at pc=0x30 -> pc=0x34, IF/ID bubble; next edge ifid_pc=0x34 valid.
- jump_target=0x102 -> pc=0x102, next edge fault=1, ifid_valid=0 thereafter, pc frozen regardless of stimulus; jump_target=0x1000 with ADDR_BITS=10 behaves the same way.
- rst_n pulsed low between clock edges while in FAULT -> all outputs clear immediately; fetch restarts at RESET_PC.
